response_stage: RTL and testbench

- Terminal stage of the MPT walker pipeline; the opposite end from the fetch stage.
- Collects finished walk transactions from the last lookup stage, tags each with its fault status, and returns them to the requester over a valid/ready master port.
- A small registered response FIFO decouples requester back-pressure from the pipeline.
- Counts and flags faulting responses for the control/status logic.

---
 rtl/mpt_pkg.sv | 27 ++
 rtl/mpt_resp_fifo.sv | 56 +++++
 rtl/response_stage.sv | 87 ++++++++
 tb/tb_response_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker pipeline: fault causes and the response header
// that prefixes every transaction returned to the requester.
package mpt_pkg;

  typedef enum logic [2:0] {
    NO_ERROR         = 3'd0,
    NOT_VALID_ADDR   = 3'd1,
    PAGE_NOT_PRESENT = 3'd2,
    ACCESS_DENIED    = 3'd3,
    MISALIGNED_ENTRY = 3'd4
  } page_format_fault_e;

  localparam int RESP_HDR_WIDTH = 1 + $bits(page_format_fault_e);

  typedef struct packed {
    logic               fault;
    page_format_fault_e cause;
  } mpt_resp_hdr_t;

  function automatic mpt_resp_hdr_t make_resp_hdr(input page_format_fault_e cause);
    mpt_resp_hdr_t hdr;
    hdr.fault = (cause != NO_ERROR);
    hdr.cause = cause;
    return hdr;
  endfunction

endpackage

// File: rtl/mpt_resp_fifo.sv
// Generic synchronous-reset FIFO. Pointers carry one extra bit so full and empty
// are told apart without a separate flag; flush empties it in one edge.
module mpt_resp_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("mpt_resp_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/response_stage.sv
// Terminal walker stage: tags finished transactions with their fault status,
// buffers them, returns them to the requester and keeps fault statistics.
module response_stage
  import mpt_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32 + RESP_HDR_WIDTH,
  parameter int FIFO_DEPTH                 = 2,
  parameter int FAULT_CNT_WIDTH            = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  response_slave_valid,
  output logic                                  response_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  response_slave_rdata,
  input  page_format_fault_e                    exception_cause_i,
  output logic                                  response_master_valid,
  input  logic                                  response_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] response_master_wdata,
  input  logic                                  response_control_flush,
  input  logic                                  response_control_clear,
  output logic [FAULT_CNT_WIDTH-1:0]            fault_count_o,
  output logic                                  fault_sticky_o
);

  if (PIPELINE_MASTER_DATA_WIDTH != PIPELINE_SLAVE_DATA_WIDTH + RESP_HDR_WIDTH) begin : g_width_check
    $error("response_stage: master width must be slave width plus response header");
  end

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_CNT = FIFO_DEPTH[CW:0];

  mpt_resp_hdr_t                         hdr;
  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  payload;
  logic [PIPELINE_MASTER_DATA_WIDTH-1:0] packed_resp;
  logic                                  push;
  logic                                  pop;
  logic                                  full;
  logic                                  empty;
  logic [CW:0]                           count;

  // Handshake: a beat moves on either port exactly at a rising edge where valid
  // and ready are both high. Ready is held low during reset and flush and never
  // looks at the requester's ready, so no combinational path crosses the stage.
  assign response_slave_ready  = rst_ni && !full && !response_control_flush;
  assign push                  = response_slave_valid && response_slave_ready;
  assign response_master_valid = !empty;
  assign pop                   = response_master_valid && response_master_ready;

  // Faulting walks return a zero payload so no partial translation leaks out.
  assign hdr         = make_resp_hdr(exception_cause_i);
  assign payload     = hdr.fault ? '0 : response_slave_rdata;
  assign packed_resp = {hdr, payload};

  mpt_resp_fifo #(
    .WIDTH (PIPELINE_MASTER_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (response_control_flush),
    .wdata  (packed_resp),
    .rdata  (response_master_wdata),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    assert (full == (count == DEPTH_CNT));
    assert (empty == (count == '0));
  end

  // Clear wins over a faulting push landing on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || response_control_clear) begin
      fault_count_o  <= '0;
      fault_sticky_o <= 1'b0;
    end else if (push && hdr.fault) begin
      if (fault_count_o != '1) fault_count_o <= fault_count_o + 1'b1;
      fault_sticky_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_response_stage.sv
// Directed bench for response_stage: a per-cycle vector table plus hand-written
// sequences for reset mid-transfer, streaming and fault-counter saturation.
module tb_response_stage;
  import mpt_pkg::*;

  localparam int W  = 32;
  localparam int MW = W + RESP_HDR_WIDTH;

  logic               clk;
  logic               rst_n;
  logic               slave_valid;
  logic [W-1:0]       slave_rdata;
  page_format_fault_e cause;
  logic               master_ready;
  logic               flush;
  logic               clear;

  logic               sready, mvalid, sticky;
  logic [MW-1:0]      wdata;
  logic [7:0]         fcnt;
  logic               sready2, mvalid2, sticky2;
  logic [MW-1:0]      wdata2;
  logic [1:0]         fcnt2;

  int checks   = 0;
  int failures = 0;
  logic [MW-1:0] exp_q[$];

  response_stage dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .response_slave_valid   (slave_valid),
    .response_slave_ready   (sready),
    .response_slave_rdata   (slave_rdata),
    .exception_cause_i      (cause),
    .response_master_valid  (mvalid),
    .response_master_ready  (master_ready),
    .response_master_wdata  (wdata),
    .response_control_flush (flush),
    .response_control_clear (clear),
    .fault_count_o          (fcnt),
    .fault_sticky_o         (sticky)
  );

  response_stage #(.FAULT_CNT_WIDTH(2)) dut_sat (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .response_slave_valid   (slave_valid),
    .response_slave_ready   (sready2),
    .response_slave_rdata   (slave_rdata),
    .exception_cause_i      (cause),
    .response_master_valid  (mvalid2),
    .response_master_ready  (master_ready),
    .response_master_wdata  (wdata2),
    .response_control_flush (flush),
    .response_control_clear (clear),
    .fault_count_o          (fcnt2),
    .fault_sticky_o         (sticky2)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          valid;
    logic [W-1:0]  rdata;
    logic [2:0]    cause;
    logic          mready;
    logic          flush;
    logic          clear;
    logic          exp_sready;
    logic          exp_mvalid;
    logic [MW-1:0] exp_wdata;
    logic [7:0]    exp_cnt;
    logic          exp_sticky;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [MW-1:0] pk(input logic f, input logic [2:0] c, input logic [W-1:0] d);
    return {f, c, d};
  endfunction

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic [2:0] c,
                              input logic mr, input logic fl, input logic cl,
                              input logic esr, input logic emv, input logic [MW-1:0] ewd,
                              input logic [7:0] ecnt, input logic est);
    vec_t r;
    r.valid = v; r.rdata = d; r.cause = c; r.mready = mr; r.flush = fl; r.clear = cl;
    r.exp_sready = esr; r.exp_mvalid = emv; r.exp_wdata = ewd;
    r.exp_cnt = ecnt; r.exp_sticky = est;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] c,
                       input logic mr, input logic fl, input logic cl);
    slave_valid  = v;
    slave_rdata  = d;
    cause        = page_format_fault_e'(c);
    master_ready = mr;
    flush        = fl;
    clear        = cl;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [2:0]   c;
    int           got;
    int           nf;

    rst_n = 1'b0;
    drive(1'b1, 32'h0000_5555, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_sready", sready, 1'b0);
    chk("reset_mvalid", mvalid, 1'b0);
    @(posedge clk);
    step();
    rst_n = 1'b1;
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);

    // valid rdata cause mready flush clear | sready mvalid wdata cnt sticky
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 0, pk(0, 0, 32'h0), 0, 0));
    vecs.push_back(mk(1, 32'h0000_1234, 0, 1, 0, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 1, pk(0, 0, 32'h0000_1234), 0, 0));
    vecs.push_back(mk(1, 32'hDEAD_BEEF, 1, 1, 0, 0, 1, 0, '0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 1, pk(1, 1, 32'h0), 1, 1));
    vecs.push_back(mk(1, 32'hAAAA_0001, 0, 0, 0, 0, 1, 0, '0, 1, 1));
    vecs.push_back(mk(1, 32'hBBBB_0002, 0, 0, 0, 0, 1, 1, pk(0, 0, 32'hAAAA_0001), 1, 1));
    vecs.push_back(mk(1, 32'hCCCC_0003, 0, 0, 0, 0, 0, 1, pk(0, 0, 32'hAAAA_0001), 1, 1));
    vecs.push_back(mk(1, 32'hCCCC_0003, 0, 0, 0, 0, 0, 1, pk(0, 0, 32'hAAAA_0001), 1, 1));
    vecs.push_back(mk(1, 32'hCCCC_0003, 0, 1, 0, 0, 0, 1, pk(0, 0, 32'hAAAA_0001), 1, 1));
    vecs.push_back(mk(1, 32'hCCCC_0003, 0, 1, 0, 0, 1, 1, pk(0, 0, 32'hBBBB_0002), 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 1, pk(0, 0, 32'hCCCC_0003), 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 1, 0, '0, 1, 1));
    vecs.push_back(mk(1, 32'hD000_0004, 0, 0, 0, 0, 1, 0, '0, 1, 1));
    vecs.push_back(mk(1, 32'hE000_0005, 3, 0, 0, 0, 1, 1, pk(0, 0, 32'hD000_0004), 1, 1));
    vecs.push_back(mk(1, 32'hF000_0006, 3, 1, 1, 0, 0, 1, pk(0, 0, 32'hD000_0004), 2, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 0, '0, 2, 1));
    vecs.push_back(mk(1, 32'h0000_0777, 0, 1, 0, 0, 1, 0, '0, 2, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 1, pk(0, 0, 32'h0000_0777), 2, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 1, 1, 0, '0, 2, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 0, '0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rdata, vecs[i].cause, vecs[i].mready, vecs[i].flush, vecs[i].clear);
      @(negedge clk);
      chk($sformatf("vec%0d_sready", i), sready, vecs[i].exp_sready);
      chk($sformatf("vec%0d_mvalid", i), mvalid, vecs[i].exp_mvalid);
      if (vecs[i].exp_mvalid || i == 0)
        chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_count", i), fcnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_sticky", i), sticky, vecs[i].exp_sticky);
      step();
    end

    // Reset with two responses buffered and a faulting beat already counted
    drive(1'b1, 32'h0000_0011, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0022, 3'd2, 1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk("midrst_pre_mvalid", mvalid, 1'b1);
    chk("midrst_pre_count", fcnt, 8'd1);
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0099, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst_sready", sready, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_mvalid", mvalid, 1'b0);
    chk("midrst_wdata", wdata, '0);
    chk("midrst_count", fcnt, 8'd0);
    chk("midrst_sticky", sticky, 1'b0);
    step();
    drive(1'b1, 32'h0000_0033, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_after_mvalid", mvalid, 1'b1);
    chk("midrst_after_wdata", wdata, pk(1'b0, 3'd0, 32'h0000_0033));
    step();

    // Streaming: 16 back-to-back beats, one response per cycle after one cycle
    got = 0;
    nf  = 0;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        d = $urandom;
        c = 3'($urandom_range(0, 4));
        drive(1'b1, d, c, 1'b1, 1'b0, 1'b0);
      end else begin
        drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk($sformatf("stream%0d_mvalid", k), mvalid, (k >= 1 && k <= 16));
      if (k < 16) begin
        chk($sformatf("stream%0d_sready", k), sready, 1'b1);
        exp_q.push_back((c != 3'd0) ? pk(1'b1, c, '0) : pk(1'b0, 3'd0, d));
        if (c != 3'd0) nf++;
      end
      if (mvalid) begin
        got++;
        if (exp_q.size() > 1) chk($sformatf("stream%0d_wdata", k), wdata, exp_q.pop_front());
        else if (k >= 16 && exp_q.size() == 1) chk($sformatf("stream%0d_wdata", k), wdata, exp_q.pop_front());
        else chk($sformatf("stream%0d_unexpected", k), 64'd1, 64'd0);
      end
      step();
    end
    chk("stream_responses", 64'(got), 64'd16);
    chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    chk("stream_faults", fcnt, 8'(nf));

    // Saturation of the 2-bit counter, then clear racing a faulting push
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 3'd1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_count", fcnt2, 2'd3);
    chk("sat_sticky", sticky2, 1'b1);
    chk("sat_wide_count", fcnt, 8'd5);
    chk("sat_mvalid", mvalid2, 1'b1);
    chk("sat_wdata", wdata2, pk(1'b1, 3'd1, '0));
    step();
    drive(1'b1, 32'h1234_5678, 3'd3, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_count", fcnt2, 2'd0);
    chk("clr_sticky", sticky2, 1'b0);
    chk("clr_wide_count", fcnt, 8'd0);
    chk("clr_wide_sticky", sticky, 1'b0);
    chk("clr_mvalid", mvalid, 1'b1);
    chk("clr_wdata", wdata, pk(1'b1, 3'd3, '0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
